uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (start, DATA_WIDTH data bits LSB first, one stop bit)
// with a small circular input FIFO. Frames run back to back while bytes are queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 1042,
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0]              T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]              T_ONE    = TW'(1);
  localparam logic [IW-1:0]              I_LAST   = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0]              I_ONE    = IW'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = (FIFO_ADDR_WIDTH + 1)'(1);
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       push;
  logic                       pop;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;

  assign o_ready = (count != CNT_FULL);
  assign push    = i_valid && o_ready;
  assign o_busy  = (state_q != IDLE) || (count != '0);
  assign o_tx    = tx_q;

  // FIFO storage: payload only, never needs clearing since count gates every read
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FSM control registers, including the registered (glitch-free) TX line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register holds the byte in flight; loaded on every pop
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  // Next-state logic; the TX line value is derived from the next state so it is registered
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          timer_d = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          shreg_d = shreg_q >> 1;
          if (idx_q == I_LAST) state_d = STOP;
          else                 idx_d   = idx_q + I_ONE;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (count != '0) begin
            // Chain straight into the next start bit so frames stay contiguous
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            idx_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a fast instance (4 clocks per bit) is compared every
// cycle against a queue-and-frame-position model; a default instance checks real bit timing.
module tb_uart_tx_fifo;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int CPB_DEF = 1042;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, tx, busy;
  logic [7:0] data_d;
  logic       valid_d;
  logic       ready_d, tx_d, busy_d;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .FIFO_ADDR_WIDTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy)
  );

  uart_tx_fifo dut_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_d), .i_valid(valid_d),
    .o_ready(ready_d), .o_tx(tx_d), .o_busy(busy_d)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: bytes waiting, byte on the wire, and cycles elapsed in its frame
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;
  bit         last_acc = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int p, input int cpb);
    int k;
    k = p / cpb;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (pos < 0) return 1'b1;
    return frame_bit(cur, pos, CPB);
  endfunction

  task automatic model_reset();
    mq.delete();
    pos = -1;
  endtask

  task automatic model_edge();
    bit acc;
    acc = valid && (mq.size() < DEPTH);
    if (pos >= 0) begin
      pos++;
      if (pos == 10 * CPB) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          pos = 0;
        end else begin
          pos = -1;
        end
      end
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
      pos = 0;
    end
    if (acc) mq.push_back(data);
    last_acc = acc;
  endtask

  task automatic cycle();
    @(posedge clk);
    last_acc = 1'b0;
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    check("tx",    32'(tx),    32'(exp_tx()));
    check("ready", 32'(ready), 32'(mq.size() < DEPTH));
    check("busy",  32'(busy),  32'((pos >= 0) || (mq.size() != 0)));
  endtask

  task automatic push(input logic [7:0] b, input bit scramble, output int waits);
    waits = 0;
    data  = b;
    valid = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      cycle();
      if (last_acc) break;
      waits++;
      if (scramble) data = 8'($urandom);
    end
    check("push_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic drain();
    for (int g = 0; g < 2000; g++) begin
      if (!busy && pos < 0 && mq.size() == 0) break;
      cycle();
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  logic [7:0] six [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
  int         w [6];
  int         wt;
  int         busy_len;

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b1;
    data    = 8'h77;
    valid_d = 1'b0;
    data_d  = 8'h00;

    // Reset held with a valid byte offered: nothing accepted, idle outputs
    for (int i = 0; i < 3; i++) cycle();
    check("rst_tx",    32'(tx),    32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("rst_nothing_sent", 32'(busy), 32'd0);

    // Single byte 0xA5
    push(8'hA5, 1'b0, wt);
    valid = 1'b0;
    busy_len = 1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (!busy) break;
      busy_len++;
    end
    check("a5_busy_len", 32'(busy_len), 32'(10 * CPB + 1));

    // Six consecutive pushes: five go straight in, the sixth waits for the first frame
    for (int i = 0; i < 6; i++) push(six[i], 1'b0, w[i]);
    valid = 1'b0;
    for (int i = 0; i < 5; i++) check("burst_no_stall", 32'(w[i]), 32'd0);
    check("burst6_waits", 32'(w[5]), 32'(10 * CPB - 3));
    drain();

    // Stall handling: data changes while o_ready is low
    for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0, wt);
    push(8'h11, 1'b1, wt);
    check("stall_waited", 32'(wt > 0), 32'd1);
    push(8'h22, 1'b1, wt);
    valid = 1'b0;
    drain();

    // Reset during data bit 3 with two bytes queued
    push(8'hC3, 1'b0, wt);
    push(8'h3C, 1'b0, wt);
    push(8'h5A, 1'b0, wt);
    valid = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (pos >= 0 && pos / CPB == 4) break;
      cycle();
    end
    check("mid_bit3", 32'(pos / CPB), 32'd4);
    check("mid_queued", 32'(mq.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx",    32'(tx),    32'd1);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    model_reset();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 12 * CPB; i++) cycle();
    check("mid_after_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      cycle();
    end
    valid = 1'b0;
    drain();

    // Default bit period: 0x3C, every cycle of the 10420-cycle frame
    data_d  = 8'h3C;
    valid_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_d = 1'b0;
    check("def_accept_busy", 32'(busy_d), 32'd1);
    check("def_accept_tx",   32'(tx_d),   32'd1);
    for (int k = 0; k < 10 * CPB_DEF; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("def_tx", 32'(tx_d), 32'(frame_bit(8'h3C, k, CPB_DEF)));
    end
    check("def_busy_end", 32'(busy_d), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("def_idle_tx",   32'(tx_d),   32'd1);
    check("def_idle_busy", 32'(busy_d), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
